// File: rtl/uart_pkg.sv
// Shared types, register map and helpers for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_EN       = 0;
  localparam int ST_BUSY     = 1;
  localparam int ST_EMPTY    = 2;
  localparam int ST_FULL     = 3;
  localparam int ST_OVF      = 4;
  localparam int ST_CNT_ZERO = 5;

  // A programmed divisor of 0 behaves like 1 so a bit always lasts at least one cycle.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular-buffer TX FIFO with wrapping pointers; head is readable without a pop
// so the transmitter can load the shift register on the same edge it pops.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // full/empty come only from the registered count, so a push while full is
  // dropped even if a pop frees a slot on the same edge.
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_top.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, baud divisor and level irq.
// Optional parity bit (CONTROL[1] selects odd) is built when UART_PARITY_EN is defined.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        txd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t   state_reg, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [15:0] baud_reg, baud_next;
  logic [15:0] div_lat_reg, div_lat_next;
  logic        par_reg, par_next;
  logic        txd_reg, txd_next;
  logic        irq_reg;
  logic [15:0] div_reg;
  logic        en_reg;
  logic        ovf_reg;
  logic        odd_bit;
  logic        pop;
  logic        push;
  logic        bit_done;
  logic        start_frame;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count_unused;
  logic        unused_wd;
  logic [31:0] status_word;

  assign unused_wd = ^wd[31:16];

  assign push = we && (a == ADDR_TXDATA);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

`ifdef UART_PARITY_EN
  logic odd_reg;
  always_ff @(posedge clk) begin
    if (!rst) begin
      odd_reg <= 1'b0;
    end else if (we && (a == ADDR_CTRL)) begin
      odd_reg <= wd[1];
    end
  end
  assign odd_bit = odd_reg;
`else
  assign odd_bit = 1'b0;
`endif

  // Register file: ovf is sticky until any write to STATUS.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_reg <= DEFAULT_DIV;
      en_reg  <= 1'b0;
      ovf_reg <= 1'b0;
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= en_reg && fifo_empty;
      if (we) begin
        case (a)
          ADDR_TXDATA: if (fifo_full) ovf_reg <= 1'b1;
          ADDR_STATUS: ovf_reg <= 1'b0;
          ADDR_DIV:    div_reg <= wd[15:0];
          default:     en_reg  <= wd[0];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      baud_reg    <= '0;
      div_lat_reg <= 16'd1;
      par_reg     <= 1'b0;
      txd_reg     <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      baud_reg    <= baud_next;
      div_lat_reg <= div_lat_next;
      par_reg     <= par_next;
      txd_reg     <= txd_next;
    end
  end

  assign bit_done    = (baud_reg == div_lat_reg - 16'd1);
  assign start_frame = en_reg && !fifo_empty;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    baud_next    = baud_reg;
    div_lat_next = div_lat_reg;
    par_next     = par_reg;
    pop          = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (start_frame) begin
          pop          = 1'b1;
          shift_next   = fifo_head;
          div_lat_next = eff_div(div_reg);
          par_next     = (^fifo_head) ^ odd_bit;
          state_next   = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_next    = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      PARITY: begin
        if (bit_done) begin
          baud_next  = '0;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_next = '0;
          // Back-to-back frames skip IDLE entirely.
          if (start_frame) begin
            pop          = 1'b1;
            shift_next   = fifo_head;
            div_lat_next = eff_div(div_reg);
            par_next     = (^fifo_head) ^ odd_bit;
            state_next   = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // txd is registered from the state being entered, so the line changes on the edge itself.
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PARITY:  txd_next = par_reg;
      default: txd_next = 1'b1;
    endcase
  end

  always_comb begin
    status_word              = '0;
    status_word[ST_EN]       = en_reg;
    status_word[ST_BUSY]     = (state_reg != IDLE);
    status_word[ST_EMPTY]    = fifo_empty;
    status_word[ST_FULL]     = fifo_full;
    status_word[ST_OVF]      = ovf_reg;
    status_word[ST_CNT_ZERO] = (baud_reg == '0);
  end

  always_comb begin
    rd = '0;
    case (a)
      ADDR_STATUS: rd = status_word;
      ADDR_DIV:    rd = {16'd0, div_reg};
      ADDR_CTRL:   rd = {30'd0, odd_bit, en_reg};
      default:     rd = '0;
    endcase
  end

  assign txd = txd_reg;
  assign irq = irq_reg;

endmodule

// File: tb/tb_uart_tx_top.sv
// Scoreboard bench for uart_tx_top: stimulus queues expected frames, a txd monitor checks them.
module tb_uart_tx_top;
  import uart_pkg::*;

`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         div;
    int         start_cyc;
    bit         b2b;
    bit         par;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        txd;
  logic        irq;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_off = 0;
  exp_t exp_q[$];

  uart_tx_top #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .we  (we),
    .wd  (wd),
    .rd  (rd),
    .txd (txd),
    .irq (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end else begin
      $display("check %s = 0x%08h ok", name, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    a = addr;
    @(negedge clk);
    chk(name, rd, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    a = ADDR_STATUS;
    @(negedge clk);
    while ((exp_q.size() != 0 || rd[ST_BUSY]) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: %0d frames still pending after %0d cycles, required 0", exp_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: decodes txd one sample per cycle and compares against the popped expectation.
  initial begin : monitor
    exp_t       cur;
    logic [10:0] bits;
    int         bit_i, cnt_i, nerr, first_bad, last_end, holdoff;
    bit         active;
    active = 0; last_end = -100; holdoff = 0;
    bit_i = 0; cnt_i = 0; nerr = 0; first_bad = -1; bits = '1;
    forever begin
      @(negedge clk);
      if (mon_off || !rst) begin
        active = 0;
        holdoff = 0;
      end else if (holdoff > 0) begin
        holdoff--;
      end else begin
        if (!active && txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
            holdoff = 200;
          end else begin
            cur = exp_q.pop_front();
            active = 1; bit_i = 0; cnt_i = 1; nerr = 0; first_bad = -1;
            bits = '1;
            bits[0] = 1'b0;
            bits[8:1] = cur.data;
            if (NBITS == 11) bits[9] = cur.par;
            if (cur.start_cyc >= 0) begin
              checks++;
              if (cyc != cur.start_cyc) begin
                errors++;
                $display("FAIL start_cycle_0x%02h: got %0d, required %0d", cur.data, cyc, cur.start_cyc);
              end
            end
            if (cur.b2b) begin
              checks++;
              if (cyc != last_end + 1) begin
                errors++;
                $display("FAIL back_to_back_0x%02h: start at %0d, required %0d", cur.data, cyc, last_end + 1);
              end
            end
          end
        end
        if (active) begin
          if (txd !== bits[bit_i]) begin
            if (nerr == 0) first_bad = bit_i;
            nerr++;
          end
          if (cnt_i >= cur.div) begin
            cnt_i = 1;
            if (bit_i == NBITS - 1) begin
              active = 0;
              last_end = cyc;
              checks++;
              if (nerr != 0) begin
                errors++;
                $display("FAIL frame_0x%02h: %0d bad samples, first at bit %0d, required 0 (div %0d)",
                         cur.data, nerr, first_bad, cur.div);
              end else begin
                $display("frame 0x%02h div %0d ok", cur.data, cur.div);
              end
            end else begin
              bit_i++;
            end
          end else begin
            cnt_i++;
          end
        end
      end
    end
  end

  logic [7:0] burst [9];
  int m;
  int busy_cycles;
  int low_cycles;

  initial begin
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
    burst[6] = 8'h77; burst[7] = 8'h88; burst[8] = 8'h99;
    rst = 1'b0; we = 1'b0; a = ADDR_TXDATA; wd = '0;
    tick(3);
    @(negedge clk);
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);

    // Test 1: reset register values
    rd_chk("rst_txdata", ADDR_TXDATA, 32'h0);
    rd_chk("rst_status", ADDR_STATUS, 32'h0000_0024);
    rd_chk("rst_div",    ADDR_DIV,    32'd868);
    rd_chk("rst_ctrl",   ADDR_CTRL,   32'h0);

    // Test 2: single 0xA5 frame at DIV=4
    wr(ADDR_DIV, 32'd4);
    wr(ADDR_CTRL, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("irq_en_empty", {31'd0, irq}, 32'd1);
    tick(1);
    m = cyc;
    exp_q.push_back('{8'hA5, 4, m + 2, 1'b0, 1'b0});
    wr(ADDR_TXDATA, 32'hA5);
    a = ADDR_STATUS;
    @(negedge clk);
    @(negedge clk);
    chk("irq_low_after_push", {31'd0, irq}, 32'd0);
    busy_cycles = 0;
    for (int i = 0; i < 100 && rd[ST_BUSY]; i++) begin
      busy_cycles++;
      @(negedge clk);
    end
    chk("busy_cycles", busy_cycles, NBITS * 4);
    chk("irq_after_frame", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    wait_idle(100);

    // Test 3: overflow with en=0, then burst back-to-back
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_DIV, 32'd2);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{burst[i], 2, -1, (i > 0), 1'b0});
      wr(ADDR_TXDATA, {24'd0, burst[i]});
    end
    rd_chk("status_full", ADDR_STATUS, 32'h0000_0028);
    wr(ADDR_TXDATA, {24'd0, burst[8]});
    rd_chk("status_ovf", ADDR_STATUS, 32'h0000_0038);
    wr(ADDR_CTRL, 32'd1);
    wait_idle(400);
    tick(30);
    rd_chk("status_after_burst", ADDR_STATUS, 32'h0000_0035);
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    rd_chk("status_ovf_cleared", ADDR_STATUS, 32'h0000_0025);

    // Test 4: divisor change mid-frame applies to the next frame only
    wr(ADDR_DIV, 32'd3);
    exp_q.push_back('{8'h3C, 3, -1, 1'b0, 1'b0});
    wr(ADDR_TXDATA, 32'h3C);
    exp_q.push_back('{8'hC3, 5, -1, 1'b1, 1'b0});
    wr(ADDR_TXDATA, 32'hC3);
    tick(6);
    wr(ADDR_DIV, 32'd5);
    wait_idle(300);
    rd_chk("div_after_change", ADDR_DIV, 32'd5);

    // Test 5: reset mid-frame aborts and flushes
    mon_off = 1'b1;
    wr(ADDR_DIV, 32'd4);
    wr(ADDR_TXDATA, 32'h5A);
    wr(ADDR_TXDATA, 32'h96);
    tick(5);
    @(negedge clk);
    chk("txd_low_before_rst", {31'd0, txd}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("txd_after_midframe_rst", {31'd0, txd}, 32'd1);
    chk("irq_after_midframe_rst", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    rd_chk("status_after_rst", ADDR_STATUS, 32'h0000_0024);
    rd_chk("div_after_rst",    ADDR_DIV,    32'd868);
    rd_chk("ctrl_after_rst",   ADDR_CTRL,   32'h0);
    wr(ADDR_CTRL, 32'd1);
    low_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cycles++;
    end
    chk("no_frame_after_flush", low_cycles, 0);
    @(posedge clk); #1;
    rd_chk("status_flushed_en", ADDR_STATUS, 32'h0000_0025);
    mon_off = 1'b0;

`ifdef UART_PARITY_EN
    // Test 6: parity bit, even then odd
    wr(ADDR_DIV, 32'd1);
    exp_q.push_back('{8'h07, 1, -1, 1'b0, 1'b1});
    wr(ADDR_TXDATA, 32'h07);
    wait_idle(100);
    wr(ADDR_CTRL, 32'd3);
    rd_chk("ctrl_odd", ADDR_CTRL, 32'd3);
    exp_q.push_back('{8'h07, 1, -1, 1'b0, 1'b0});
    wr(ADDR_TXDATA, 32'h07);
    wait_idle(100);
`else
    wr(ADDR_CTRL, 32'd3);
    rd_chk("ctrl_no_odd", ADDR_CTRL, 32'd1);
`endif

    tick(10);
    chk("pending_frames", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
